inst_fetcher: RTL and testbench
===============================

Name: inst_fetcher

Overview:
- Instruction-fetch front end; initiator of the IF port of the memory controller (drives the enable/PC side, consumes the done/result side).
- Holds the PC and a direct-mapped instruction cache.
- Hits stream one instruction per cycle to the decoder; misses issue a single-word fetch to the memory controller and retry after the fill.
- Redirects to a new PC on rollback.

Parameters:
- ICACHE_IDX_W, 6, index width; cache holds 2^ICACHE_IDX_W one-word lines.
- RESET_PC, 32'h0, PC loaded at reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global ready; low freezes all state and outputs
- rollback  in  1  pipeline flush request
- rollback_pc  in  32  redirect target on rollback
- issue_stall  in  1  downstream (decoder/RS/ROB) cannot accept an instruction this cycle
- inst_valid  out  1  instruction delivered this cycle
- inst  out  32  instruction word
- inst_pc  out  32  address of inst
- mc_enable  out  1  fetch request to memory controller
- mc_pc  out  32  fetch address, word-aligned
- mc_done  in  1  one-cycle pulse: mc_result valid
- mc_result  in  32  fetched word

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the rising edge. rst has priority over rdy.
- Reset values:
  - pc = RESET_PC
  - all cache valid bits = 0
  - inst_valid = 0, inst = 0, inst_pc = 0
  - mc_enable = 0, mc_pc = 0
  - state = IDLE
- rdy = 0: no state, cache or output changes. Any mc_done seen while rdy = 0 is ignored. The memory controller does not pulse mc_done while rdy is low.
- Cache addressing:
  - index = pc[ICACHE_IDX_W+1:2]
  - tag = pc[31:ICACHE_IDX_W+2]
  - hit = valid[index] && tag match
  - lookup is combinational on the current pc
- pc[1:0] is always 0. rollback_pc[1:0] is forced to 0 on load.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 = 0.
- Priority each rdy cycle, highest first: rst, rollback, normal operation.
- rollback (rdy = 1):
  - pc <= {rollback_pc[31:2], 2'b00}
  - inst_valid <= 0
  - mc_enable <= 0
  - state <= IDLE
  - an mc_done in the same cycle is discarded: no cache write, no delivery
- State machine, two states:
  - IDLE, hit and not issue_stall: next cycle inst_valid = 1, inst = line data, inst_pc = pc; pc <= pc + 4. Back-to-back hits give one instruction per cycle.
  - IDLE, hit and issue_stall: inst_valid <= 0, pc holds.
  - IDLE, miss: mc_enable <= 1, mc_pc <= pc, state <= WAIT, inst_valid <= 0. A miss is issued even while issue_stall is high (prefetch into the cache).
  - WAIT: mc_enable and mc_pc held stable until mc_done.
  - WAIT, on mc_done: write line[mc_pc index] = {valid = 1, tag of mc_pc, mc_result}; mc_enable <= 0; state <= IDLE. No direct delivery; the next IDLE cycle hits.
  - Miss-to-delivery latency = memory controller latency + 2 cycles.
- inst_valid is a per-cycle strobe. The consumer samples it only on cycles where it drove issue_stall = 0 in the previous cycle. The fetcher never asserts inst_valid in the cycle after issue_stall was high.
- mc_enable must be 0 for at least one cycle between consecutive requests (the memory controller latches on rising request).
- mc_done while in IDLE (stale, after a rollback) is ignored.
- Cache fill replaces the line unconditionally (direct-mapped eviction).
- No prediction: sequential pc + 4 only. Redirects come exclusively from rollback.

Decomposition:
- definition.v additions:
  - ADDR_TYPE 31:0 and DATA_TYPE 31:0 (reuse existing)
  - ICACHE_IDX_W default
  - FETCH_IDLE / FETCH_WAIT state encodings
- Sub-module icache:
  - valid/tag/data arrays
  - combinational hit/data read
  - synchronous single-port write with synchronous clear on rst
- inst_fetcher holds the PC, FSM and output registers.

Test Plan:
- Cold start: rst 1 for 2 cycles then 0, RESET_PC = 0 → mc_enable = 1 and mc_pc = 0 next cycle. Answer mc_done with 32'h00000013 after 4 cycles → inst_valid = 1, inst = 32'h13, inst_pc = 0 two cycles after mc_done; then fetch of pc 4 issues.
- Hit streaming: prefill pcs 0x0..0xC, rollback to 0 → four consecutive inst_valid cycles with inst_pc 0, 4, 8, C and mc_enable = 0 throughout.
- Stall: issue_stall high for 3 cycles mid-stream → inst_valid 0 during the stall; the sequence resumes without skipping or duplicating a PC.
- Rollback in WAIT: miss at 0x100, rollback_pc = 0x203 while waiting, mc_done arrives the same cycle → mc_enable drops, the 0x100 line stays invalid, the next request has mc_pc = 0x200.
- Eviction (ICACHE_IDX_W = 6): fetch 0x0, then 0x100 (same index) → refetching 0x0 misses and issues mc_pc = 0.
- rdy low for 5 cycles during WAIT with mc_done held off → outputs frozen; normal completion after rdy returns high. rst during WAIT → all reset values on the next edge, and a later mc_done is ignored.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg
//   Shared types and constants for the instruction-fetch front end:
//   address/data word types, default cache index width, fetch FSM
//   state encodings and the sequential PC increment.
package inst_fetcher_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam int ICACHE_IDX_W_DEF = 6;

    localparam logic [0:0] FETCH_IDLE = 1'b0;
    localparam logic [0:0] FETCH_WAIT = 1'b1;

    // Sequential PC step; wraps modulo 2^32.
    function automatic addr_t next_pc(input addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetcher_icache.sv
// inst_fetcher_icache
//   Direct-mapped instruction cache with 2^IDX_W one-word lines.
//   Lookup is combinational on rd_pc; fills are a single synchronous
//   write port. rst clears every valid bit; tag/data arrays are not reset.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   rd_pc          lookup address
//   hit, rd_data   lookup result (rd_data meaningful only when hit)
//   wr_en          write one line this cycle
//   wr_pc, wr_data line address and word to store
module inst_fetcher_icache
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t rd_pc,
    output logic  hit,
    output data_t rd_data,
    input  logic  wr_en,
    input  addr_t wr_pc,
    input  data_t wr_data
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem [LINES];
    data_t            data_mem [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Byte-offset bits are always zero on word-aligned PCs.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_idx  = rd_pc[IDX_W+1:2];
    assign wr_idx  = wr_pc[IDX_W+1:2];
    assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_pc[31:IDX_W+2]);
    assign rd_data = data_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_pc[31:IDX_W+2];
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher
//   Instruction-fetch front end. Holds the PC and a direct-mapped
//   instruction cache; hits stream one instruction per cycle, misses
//   issue a single-word request to the memory controller and retry the
//   lookup after the fill. rollback redirects the PC.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       global ready; low freezes everything
//   rollback, rollback_pc     pipeline flush and redirect target
//   issue_stall               consumer cannot take an instruction
//   inst_valid, inst, inst_pc delivered instruction strobe/word/address
//   mc_enable, mc_pc          fetch request to the memory controller
//   mc_done, mc_result        fetch completion pulse and data
//
// state      | meaning
// FETCH_IDLE | looking up pc in the cache each cycle
// FETCH_WAIT | miss outstanding; request held until mc_done
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int    ICACHE_IDX_W = ICACHE_IDX_W_DEF,
    parameter addr_t RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        issue_stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        mc_enable,
    output logic [31:0] mc_pc,
    input  logic        mc_done,
    input  logic [31:0] mc_result
);

    logic [0:0] state;
    addr_t      pc;
    logic       hit;
    data_t      hit_data;
    logic       fill_en;

    logic unused_rollback_lsb;
    assign unused_rollback_lsb = ^rollback_pc[1:0];

    // A completion coinciding with rollback belongs to a squashed fetch.
    assign fill_en = !rst && rdy && !rollback && (state == FETCH_WAIT) && mc_done;

    inst_fetcher_icache #(
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_pc   (pc),
        .hit     (hit),
        .rd_data (hit_data),
        .wr_en   (fill_en),
        .wr_pc   (mc_pc),
        .wr_data (mc_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= FETCH_IDLE;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            mc_enable  <= 1'b0;
            mc_pc      <= '0;
        end else if (rdy) begin
            if (rollback) begin
                pc         <= {rollback_pc[31:2], 2'b00};
                state      <= FETCH_IDLE;
                inst_valid <= 1'b0;
                mc_enable  <= 1'b0;
            end else if (state == FETCH_IDLE) begin
                if (hit) begin
                    inst_valid <= !issue_stall;
                    if (!issue_stall) begin
                        inst    <= hit_data;
                        inst_pc <= pc;
                        pc      <= next_pc(pc);
                    end
                end else begin
                    // Misses go out even under issue_stall so the line is
                    // ready by the time the consumer frees up.
                    inst_valid <= 1'b0;
                    mc_enable  <= 1'b1;
                    mc_pc      <= pc;
                    state      <= FETCH_WAIT;
                end
            end else begin
                // The fill only lands in the cache; the following IDLE
                // cycle re-looks-up pc and hits. Dropping mc_enable here
                // also guarantees a low cycle before the next request.
                inst_valid <= 1'b0;
                if (mc_done) begin
                    mc_enable <= 1'b0;
                    state     <= FETCH_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher
//   Directed scenarios followed by a randomized run, all compared every
//   cycle against a behavioural model that tracks the PC, a line-address
//   keyed cache image and the expected output registers.
module tb_inst_fetcher;

    localparam int IDX_W = 6;
    localparam int LINES = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        issue_stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mc_enable;
    logic [31:0] mc_pc;
    logic        mc_done;
    logic [31:0] mc_result;

    inst_fetcher #(
        .ICACHE_IDX_W (IDX_W),
        .RESET_PC     (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rollback    (rollback),
        .rollback_pc (rollback_pc),
        .issue_stall (issue_stall),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .mc_enable   (mc_enable),
        .mc_pc       (mc_pc),
        .mc_done     (mc_done),
        .mc_result   (mc_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_pc;
    bit          m_wait;
    bit          m_valid [LINES];
    logic [31:0] m_addr  [LINES];
    logic [31:0] m_data  [LINES];
    logic        e_inst_valid;
    logic [31:0] e_inst;
    logic [31:0] e_inst_pc;
    logic        e_mc_enable;
    logic [31:0] e_mc_pc;

    // memory-controller responder
    bit auto_mc;
    bit mc_pending;
    int mc_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Rotate-left-by-8 keeps every address distinct; address 0 gives 32'h13.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], a[31:24]} ^ 32'h13;
    endfunction

    task automatic model_update();
        int k;
        if (rst) begin
            m_pc = 32'h0;
            m_wait = 1'b0;
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            e_inst_valid = 1'b0;
            e_inst = '0;
            e_inst_pc = '0;
            e_mc_enable = 1'b0;
            e_mc_pc = '0;
        end else if (rdy) begin
            if (rollback) begin
                m_pc = rollback_pc & 32'hFFFF_FFFC;
                m_wait = 1'b0;
                e_inst_valid = 1'b0;
                e_mc_enable = 1'b0;
            end else if (m_wait) begin
                e_inst_valid = 1'b0;
                if (mc_done) begin
                    k = int'(e_mc_pc[IDX_W+1:2]);
                    m_valid[k] = 1'b1;
                    m_addr[k] = e_mc_pc;
                    m_data[k] = mc_result;
                    e_mc_enable = 1'b0;
                    m_wait = 1'b0;
                end
            end else begin
                k = int'(m_pc[IDX_W+1:2]);
                if (m_valid[k] && m_addr[k] == m_pc) begin
                    e_inst_valid = !issue_stall;
                    if (!issue_stall) begin
                        e_inst = m_data[k];
                        e_inst_pc = m_pc;
                        m_pc = m_pc + 32'd4;
                    end
                end else begin
                    e_inst_valid = 1'b0;
                    e_mc_enable = 1'b1;
                    e_mc_pc = m_pc;
                    m_wait = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("inst_valid", 32'(inst_valid), 32'(e_inst_valid));
        check_eq("inst", inst, e_inst);
        check_eq("inst_pc", inst_pc, e_inst_pc);
        check_eq("mc_enable", 32'(mc_enable), 32'(e_mc_enable));
        check_eq("mc_pc", mc_pc, e_mc_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    // Decides mc_done/mc_result for the coming edge from the expected request.
    task automatic mc_respond();
        mc_done = 1'b0;
        if (!e_mc_enable) begin
            mc_pending = 1'b0;
            if (rdy && $urandom_range(0, 15) == 0) begin
                mc_done = 1'b1;
                mc_result = $urandom;
            end
        end else if (!mc_pending) begin
            mc_pending = 1'b1;
            mc_count = $urandom_range(1, 4);
        end else if (rdy) begin
            mc_count--;
            if (mc_count == 0) begin
                mc_done = 1'b1;
                mc_result = mem_word(e_mc_pc);
                mc_pending = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        if (auto_mc) mc_respond();
        tick();
    endtask

    task automatic do_rollback(input logic [31:0] target);
        rollback = 1'b1;
        rollback_pc = target;
        cycle();
        rollback = 1'b0;
    endtask

    task automatic run_until_delivered(input logic [31:0] target, input int budget, input string tag);
        int n = 0;
        while (!(inst_valid && inst_pc == target) && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag, {inst_valid, inst_pc[30:0]}, {1'b1, target[30:0]});
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        rollback = 1'b0;
        rollback_pc = '0;
        issue_stall = 1'b0;
        mc_done = 1'b0;
        mc_result = '0;
        auto_mc = 1'b0;
        mc_pending = 1'b0;
        mc_count = 0;

        // cold start
        tick();
        tick();
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_mc_enable", 32'(mc_enable), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("cold_mc_enable", 32'(mc_enable), 32'd1);
        check_eq("cold_mc_pc", mc_pc, 32'h0);
        tick();
        tick();
        tick();
        mc_done = 1'b1;
        mc_result = 32'h0000_0013;
        tick();
        mc_done = 1'b0;
        check_eq("fill_drop_enable", 32'(mc_enable), 32'd0);
        tick();
        check_eq("cold_inst_valid", 32'(inst_valid), 32'd1);
        check_eq("cold_inst", inst, 32'h13);
        check_eq("cold_inst_pc", inst_pc, 32'h0);
        tick();
        check_eq("next_fetch_pc", mc_pc, 32'h4);
        check_eq("next_fetch_en", 32'(mc_enable), 32'd1);

        // prefill 0x4..0xC, then stream 0..C out of the cache
        auto_mc = 1'b1;
        mc_pending = 1'b0;
        run_until_delivered(32'hC, 100, "prefill_reach");
        do_rollback(32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("stream_valid", 32'(inst_valid), 32'd1);
            check_eq("stream_pc", inst_pc, 32'(4 * i));
            check_eq("stream_no_req", 32'(mc_enable), 32'd0);
        end

        // stall mid-stream
        do_rollback(32'h0);
        cycle();
        cycle();
        issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("stall_quiet", 32'(inst_valid), 32'd0);
        end
        issue_stall = 1'b0;
        cycle();
        check_eq("stall_resume_pc", inst_pc, 32'h8);
        cycle();
        check_eq("stall_next_pc", inst_pc, 32'hC);

        // rollback while waiting, with a coincident completion
        do_rollback(32'h100);
        auto_mc = 1'b0;
        mc_done = 1'b0;
        tick();
        check_eq("miss100_pc", mc_pc, 32'h100);
        tick();
        tick();
        rollback = 1'b1;
        rollback_pc = 32'h203;
        mc_done = 1'b1;
        mc_result = 32'h0BAD_0BAD;
        tick();
        rollback = 1'b0;
        mc_done = 1'b0;
        check_eq("rb_wait_drop", 32'(mc_enable), 32'd0);
        tick();
        check_eq("rb_wait_req_en", 32'(mc_enable), 32'd1);
        check_eq("rb_wait_req_pc", mc_pc, 32'h200);
        tick();
        mc_done = 1'b1;
        mc_result = mem_word(32'h200);
        tick();
        mc_done = 1'b0;

        // eviction between 0x0 and 0x100 (same index)
        auto_mc = 1'b1;
        mc_pending = 1'b0;
        do_rollback(32'h0);
        run_until_delivered(32'h0, 50, "evict_fetch0");
        do_rollback(32'h100);
        run_until_delivered(32'h100, 50, "evict_fetch100");
        check_eq("evict_data100", inst, mem_word(32'h100));
        do_rollback(32'h0);
        cycle();
        check_eq("evict_refetch_en", 32'(mc_enable), 32'd1);
        check_eq("evict_refetch_pc", mc_pc, 32'h0);

        // rdy low during WAIT
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("frozen_en", 32'(mc_enable), 32'd1);
            check_eq("frozen_valid", 32'(inst_valid), 32'd0);
        end
        rdy = 1'b1;
        run_until_delivered(32'h0, 50, "after_freeze");

        // reset during WAIT, then a stale completion
        do_rollback(32'h400);
        cycle();
        check_eq("miss400_en", 32'(mc_enable), 32'd1);
        auto_mc = 1'b0;
        mc_done = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("wait_rst_en", 32'(mc_enable), 32'd0);
        check_eq("wait_rst_pc", mc_pc, 32'h0);
        check_eq("wait_rst_inst", inst, 32'h0);
        check_eq("wait_rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b0;
        mc_done = 1'b1;
        mc_result = 32'hDEAD_BEEF;
        tick();
        mc_done = 1'b0;
        check_eq("post_rst_req_en", 32'(mc_enable), 32'd1);
        check_eq("post_rst_req_pc", mc_pc, 32'h0);
        auto_mc = 1'b1;
        mc_pending = 1'b0;
        run_until_delivered(32'h0, 50, "post_rst_deliver");
        check_eq("post_rst_inst", inst, 32'h13);

        // randomized run
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            issue_stall = ($urandom_range(0, 2) == 0);
            rollback = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: rollback_pc = 32'($urandom_range(0, 255));
                1: rollback_pc = 32'h100 + 32'($urandom_range(0, 63));
                2: rollback_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rollback_pc = $urandom & 32'h0000_0FFF;
            endcase
            cycle();
        end
        rst = 1'b0;
        rdy = 1'b1;
        rollback = 1'b0;
        issue_stall = 1'b0;
        mc_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
